// File: rtl/seq_mantissa_mult.sv
// Iterative unsigned shift-add mantissa multiplier.
// Retires BITS_PER_CYCLE multiplier bits per RUN cycle; start/done handshake.
module seq_mantissa_mult #(
  parameter int INPUT_SIZE     = 10,
  parameter int BITS_PER_CYCLE = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [INPUT_SIZE-1:0]     A,
  input  logic [INPUT_SIZE-1:0]     B,
  output logic                      ready,
  output logic                      busy,
  output logic                      done,
  output logic [2*INPUT_SIZE-1:0]   P
);

  localparam int C   = (INPUT_SIZE + BITS_PER_CYCLE - 1)
                       / BITS_PER_CYCLE;
  localparam int PW  = 2 * INPUT_SIZE;
  localparam int MBW = BITS_PER_CYCLE * C;
  localparam int CW  = (C > 1) ? $clog2(C) : 1;

  localparam logic [CW-1:0] LAST = CW'(C - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ma_q, ma_d;
  logic [MBW-1:0]  mb_q, mb_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   i_q, i_d;
  logic [PW-1:0]   p_q, p_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [PW-1:0]   sum;

  // Partial products of this cycle's multiplier nibble, weighted by i.
  always_comb begin
    sum = acc_q;
    for (int k = 0; k < BITS_PER_CYCLE; k++) begin
      if (mb_q[k]) begin
        sum = sum + (ma_q << (int'(i_q) * BITS_PER_CYCLE + k));
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    acc_d   = acc_q;
    i_d     = i_q;
    p_d     = p_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          ma_d    = PW'(A);
          mb_d    = MBW'(B);
          acc_d   = '0;
          i_d     = '0;
          ready_d = 1'b0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d = sum;
        mb_d  = mb_q >> BITS_PER_CYCLE;
        i_d   = i_q + 1'b1;
        if (i_q == LAST) begin
          p_d     = sum;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ma_q    <= '0;
      mb_q    <= '0;
      acc_q   <= '0;
      i_q     <= '0;
      p_q     <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      acc_q   <= acc_d;
      i_q     <= i_d;
      p_q     <= p_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign P     = p_q;

endmodule

// File: tb/tb_seq_mantissa_mult.sv
// Scoreboard bench for seq_mantissa_mult: directed operands,
// monitor checks product and latency on every done pulse.
module tb_seq_mantissa_mult;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  A = '0;
  logic [9:0]  B = '0;
  logic        ready, busy, done;
  logic [19:0] P;

  seq_mantissa_mult #(.INPUT_SIZE(10)) dut (
    .clk(clk), .rst(rst), .start(start),
    .A(A), .B(B),
    .ready(ready), .busy(busy), .done(done), .P(P)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [19:0] p;
    int          c;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  // Monitor: pop and compare on every done pulse.
  exp_t e;
  logic prev_done = 1'b0;
  always @(posedge clk) begin
    #1;
    if (!rst && done) begin
      chk("done_width", 32'(prev_done), 0);
      if (sbq.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = sbq.pop_front();
        chk("P", 32'(P), 32'(e.p));
        chk("latency", cyc, e.c);
      end
    end
    prev_done = done;
  end

  task automatic wait_ready();
    int k = 0;
    while (!ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!ready) chk("ready_timeout", 0, 1);
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic go(input logic [9:0] a,
                    input logic [9:0] b,
                    input logic [19:0] prod,
                    input bit push);
    wait_ready();
    A = a;
    B = b;
    start = 1'b1;
    if (push) sbq.push_back('{p: prod, c: cyc + 4});
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_P", 32'(P), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(ready), 1);
    rst = 1'b0;

    A = 10'd7;
    B = 10'd9;
    repeat (10) begin
      @(negedge clk);
      chk("idle_ready", 32'(ready), 1);
      chk("idle_P", 32'(P), 0);
    end

    go(10'd3, 10'd5, 20'd15, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("run_busy", 32'(busy), 1);
      chk("run_ready", 32'(ready), 0);
      @(negedge clk);
    end
    chk("done_busy", 32'(busy), 0);
    chk("done_hi", 32'(done), 1);
    chk("done_P", 32'(P), 15);
    @(negedge clk);
    chk("post_ready", 32'(ready), 1);
    chk("post_done", 32'(done), 0);

    go(10'd1023, 10'd1023, 20'hFF801, 1'b1);
    go(10'd0, 10'd777, 20'd0, 1'b1);
    go(10'd512, 10'd2, 20'd1024, 1'b1);

    go(10'd10, 10'd20, 20'd200, 1'b1);
    A = 10'd1;
    B = 10'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    // Held start: accepts every 5 cycles, operands latched at accept.
    wait_ready();
    A = 10'd6;
    B = 10'd7;
    start = 1'b1;
    sbq.push_back('{p: 20'd42, c: cyc + 4});
    sbq.push_back('{p: 20'd143, c: cyc + 9});
    @(negedge clk);
    A = 10'd11;
    B = 10'd13;
    repeat (5) @(negedge clk);
    start = 1'b0;
    A = 10'd0;
    B = 10'd0;

    // Abort mid-RUN with reset: no done may follow.
    go(10'd100, 10'd100, 20'd0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_P", 32'(P), 0);
    chk("abort_ready", 32'(ready), 1);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);

    go(10'd12, 10'd34, 20'd408, 1'b1);

    for (int k = 0; k < 20 && sbq.size() > 0; k++) @(negedge clk);
    chk("drain", sbq.size(), 0);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_mantissa_mult.md
Name: seq_mantissa_mult

Overview:
Iterative unsigned shift-add multiplier for FP mantissas. It is the multiply-side counterpart of the division unit chain. It retires 4 multiplier bits per clock, adding 4 shifted partial products per cycle. It sits in the FP_multiplier datapath with a start/done handshake toward the FP control FSM.

Parameters:
INPUT_SIZE, 10, width of each operand in bits; product is 2*INPUT_SIZE bits.
BITS_PER_CYCLE, 4 (fixed, not overridable in use), multiplier bits consumed per RUN cycle.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  request a new multiply; sampled only when ready=1.
A  input  INPUT_SIZE  multiplicand; latched on accepted start.
B  input  INPUT_SIZE  multiplier; latched on accepted start.
ready  output  1  high only in IDLE.
busy  output  1  high in RUN.
done  output  1  one-cycle pulse; P valid and new.
P  output  2*INPUT_SIZE  product register; holds its value until the next done.

Behaviour:
- C = ceil(INPUT_SIZE/4) RUN cycles. C = 3 for the default.
- Reset (async, any state): state=IDLE, P=0, done=0, busy=0, ready=1. Internal acc, multiplicand, multiplier shift register and counter all cleared. Reset mid-RUN aborts the operation; no done is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE: ready=1. A rising edge with start=1 does all of the following:
  - latch A into ma (zero-extended to 2*INPUT_SIZE);
  - latch B into mb (zero-padded to 4*C bits);
  - clear acc and counter i;
  - go to RUN.
- IDLE with start=0: remain in IDLE.
- RUN: busy=1, ready=0. Each edge does all of the following:
  - acc <= acc + sum over k=0..3 of (mb[k] ? ma << (4*i+k) : 0);
  - mb >>= 4;
  - i <= i+1.
- RUN exit: on the edge where i=C-1, load P with the final acc sum (same-edge value), assert done, and go to DONE.
- DONE: done=1 for exactly one cycle, ready=0, busy=0. The next edge goes to IDLE and done=0.
- Latency: start accepted at edge T; done and new P are visible after edge T+C. The next start can be accepted at edge T+C+2 (first IDLE cycle). Throughput is one product per C+2 cycles.
- start while in RUN or DONE is ignored. A/B changes after acceptance have no effect.
- No early termination: zero or small operands still take C cycles.
- Width: acc and P are 2*INPUT_SIZE bits. (2^N-1)^2 < 2^(2N), so there is no overflow. Padded multiplier bits above INPUT_SIZE are 0 and contribute nothing.
- P changes only on done edges or reset.

Test Plan:
- Assert rst, then release -> P=0, done=0, busy=0, ready=1; A=7, B=9 with start=0 for 10 cycles -> no change.
- A=3, B=5, start for 1 cycle -> busy high 3 cycles, then done for 1 cycle with P=15, then ready=1.
- A=1023, B=1023 -> P=1046529 (0xFF801) exactly 3 edges after the start edge; done width is 1 cycle.
- A=0, B=777 -> P=0 and still a 3-cycle RUN. Then A=512, B=2 -> P=1024.
- Start A=10, B=20; in RUN pulse start with A=1, B=1 -> ignored, P=200. Hold start high continuously -> new operation accepted on the first IDLE cycle only, with 5 cycles per product.
- Start A=100, B=100; assert rst in the 2nd RUN cycle -> immediate P=0, ready=1, no done. After release, A=12, B=34 -> P=408.
